fe_seq_ctrl: RTL and testbench

- Sequencing controller for the fetch stage: program counter, synchronous instruction memory and FE/ID pipeline latch.
- Arbitrates redirect, stall and halt requests into one set of PC and latch controls.
- Squashes wrong-path fetches caused by the one-cycle memory read latency and inserts bubbles into ID.
- Keeps saturating performance counters for stall cycles and redirects.

---
 rtl/fe_seq_ctrl_if.sv | 33 +++
 rtl/fe_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_fe_seq_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fe_seq_ctrl_if.sv
// Request/control bundle between the fetch-stage sequencer and its
// neighbours (hazard unit, branch resolution, PC register, FE/ID latch).
interface fe_seq_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              stall_req;
  logic              redirect_req;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halt_req;
  logic              resume;
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              pc_wr_en;
  logic              fe_id_wr_en;
  logic              fe_id_flush;
  logic              fetch_valid;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stall_req, redirect_req, redirect_addr, halt_req, resume,
    input  pc_sel, pc_load_addr, pc_wr_en, fe_id_wr_en, fe_id_flush,
           fetch_valid, state_o, stall_cnt, redirect_cnt
  );

  modport slave (
    input  stall_req, redirect_req, redirect_addr, halt_req, resume,
    output pc_sel, pc_load_addr, pc_wr_en, fe_id_wr_en, fe_id_flush,
           fetch_valid, state_o, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/fe_seq_ctrl.sv
// Fetch-stage sequencer: arbitrates redirect/stall/halt into PC and FE/ID
// latch controls, squashes stale fetches and keeps saturating counters.
module fe_seq_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'd16,
  parameter int                SQUASH_SLOTS = 1,
  parameter int                CNT_W        = 16
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  fe_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [1:0]       SQ_INIT = 2'(SQUASH_SLOTS);
  localparam logic [1:0]       SQ_ONE  = 2'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_sq;
  logic [1:0]        w_next_sq;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_redirect_cnt;
  logic              w_pc_sel;
  logic [ADDR_W-1:0] w_pc_load_addr;
  logic              w_pc_wr_en;
  logic              w_fe_id_wr_en;
  logic              w_fe_id_flush;
  logic              w_stall_ok;

  // State and squash-slot register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FLUSH;
      r_sq    <= SQ_INIT;
    end else begin
      r_state <= w_next_state;
      r_sq    <= w_next_sq;
    end
  end

  // Next-state: redirect restarts the squash window, except that HALT is sticky
  always_comb begin
    w_next_state = r_state;
    w_next_sq    = r_sq;
    if (bus.redirect_req) begin
      w_next_sq    = SQ_INIT;
      w_next_state = (r_state == ST_HALT) ? ST_HALT : ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.stall_req && bus.halt_req) begin
            w_next_state = ST_HALT;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (bus.stall_req) begin
            w_next_state = ST_FLUSH;
          end else begin
            w_next_sq    = r_sq - SQ_ONE;
            w_next_state = (r_sq == SQ_ONE) ? ST_RUN : ST_FLUSH;
          end
        end
        ST_HALT: begin
          if (bus.resume && !bus.halt_req) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_HALT;
          end
        end
        default: begin
          w_next_state = ST_FLUSH;
          w_next_sq    = SQ_INIT;
        end
      endcase
    end
  end

  // Mealy outputs; reset is folded in so the PC is forced while held
  always_comb begin
    w_pc_sel       = 1'b0;
    w_pc_load_addr = RESET_PC;
    w_pc_wr_en     = 1'b1;
    w_fe_id_wr_en  = 1'b1;
    w_fe_id_flush  = 1'b0;
    w_stall_ok     = 1'b0;
    if (!reset_n) begin
      w_pc_sel      = 1'b1;
      w_fe_id_flush = 1'b1;
    end else if (bus.redirect_req) begin
      w_pc_sel       = 1'b1;
      w_pc_load_addr = bus.redirect_addr;
      w_fe_id_flush  = 1'b1;
    end else begin
      case (r_state)
        ST_HALT: begin
          w_pc_wr_en    = 1'b0;
          w_fe_id_flush = 1'b1;
        end
        ST_RUN, ST_FLUSH: begin
          if (bus.stall_req) begin
            w_pc_wr_en    = 1'b0;
            w_fe_id_wr_en = 1'b0;
            w_stall_ok    = 1'b1;
          end else begin
            w_fe_id_flush = (r_state == ST_FLUSH);
          end
        end
        default: begin
          w_pc_sel      = 1'b1;
          w_fe_id_flush = 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt    <= {CNT_W{1'b0}};
      r_redirect_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_ok && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (bus.redirect_req && (r_redirect_cnt != CNT_MAX)) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
      end
    end
  end

  assign bus.pc_sel       = w_pc_sel;
  assign bus.pc_load_addr = w_pc_load_addr;
  assign bus.pc_wr_en     = w_pc_wr_en;
  assign bus.fe_id_wr_en  = w_fe_id_wr_en;
  assign bus.fe_id_flush  = w_fe_id_flush;
  assign bus.fetch_valid  = w_fe_id_wr_en & ~w_fe_id_flush;
  assign bus.state_o      = r_state;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_fe_seq_ctrl.sv
// Bench for fe_seq_ctrl: two instances (1 and 2 squash slots, 4-bit counters on
// the second) share stimulus and are checked against a rule-level model.
module tb_fe_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        t_stall;
  logic        t_redir;
  logic [15:0] t_addr;
  logic        t_halt;
  logic        t_resume;

  int n_checks = 0;
  int n_errors = 0;

  // model state per instance: mode 0 RUN, 1 FLUSH, 2 HALT
  int m_mode   [2];
  int m_left   [2];
  int m_stalls [2];
  int m_redirs [2];
  int slots    [2] = '{1, 2};
  int cmax     [2] = '{65535, 15};

  fe_seq_ctrl_if #(.ADDR_W(16), .CNT_W(16)) if1 ();
  fe_seq_ctrl_if #(.ADDR_W(16), .CNT_W(4))  if2 ();

  assign if1.stall_req = t_stall;  assign if2.stall_req = t_stall;
  assign if1.redirect_req = t_redir; assign if2.redirect_req = t_redir;
  assign if1.redirect_addr = t_addr; assign if2.redirect_addr = t_addr;
  assign if1.halt_req = t_halt;    assign if2.halt_req = t_halt;
  assign if1.resume = t_resume;    assign if2.resume = t_resume;

  fe_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'd16), .SQUASH_SLOTS(1), .CNT_W(16)) u_dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .bus(if1.slave));
  fe_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'd16), .SQUASH_SLOTS(2), .CNT_W(4)) u_dut2 (
    .CLOCK_50(clk), .reset_n(reset_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 1; m_left[k] = slots[k]; m_stalls[k] = 0; m_redirs[k] = 0;
    end
  endtask

  // what one clock edge does to the model, from the current inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_mode[k] = 1; m_left[k] = slots[k]; m_stalls[k] = 0; m_redirs[k] = 0;
      end else if (t_redir) begin
        if (m_redirs[k] < cmax[k]) m_redirs[k]++;
        if (m_mode[k] != 2) begin m_mode[k] = 1; m_left[k] = slots[k]; end
      end else if (m_mode[k] != 2 && t_stall) begin
        if (m_stalls[k] < cmax[k]) m_stalls[k]++;
      end else if (m_mode[k] == 0 && t_halt) begin
        m_mode[k] = 2;
      end else if (m_mode[k] == 1) begin
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 0;
      end else if (m_mode[k] == 2 && t_resume && !t_halt) begin
        m_mode[k] = 0;
      end
    end
  endtask

  task automatic check_one(input int k, input logic sel, input logic [15:0] addr,
                           input logic pw, input logic fw, input logic fl, input logic fv,
                           input logic [1:0] st, input logic [15:0] sc, input logic [15:0] rc);
    logic e_sel, e_pw, e_fw, e_fl;
    logic [15:0] e_addr;
    e_addr = 16'd16;
    if (!reset_n) begin
      e_sel = 1'b1; e_pw = 1'b1; e_fw = 1'b1; e_fl = 1'b1;
    end else if (t_redir) begin
      e_sel = 1'b1; e_pw = 1'b1; e_fw = 1'b1; e_fl = 1'b1; e_addr = t_addr;
    end else if (m_mode[k] == 2) begin
      e_sel = 1'b0; e_pw = 1'b0; e_fw = 1'b1; e_fl = 1'b1;
    end else if (t_stall) begin
      e_sel = 1'b0; e_pw = 1'b0; e_fw = 1'b0; e_fl = 1'b0;
    end else begin
      e_sel = 1'b0; e_pw = 1'b1; e_fw = 1'b1; e_fl = (m_mode[k] == 1);
    end
    chk($sformatf("d%0d_pc_sel", k), 32'(sel), 32'(e_sel));
    if (e_sel) chk($sformatf("d%0d_pc_load_addr", k), 32'(addr), 32'(e_addr));
    chk($sformatf("d%0d_pc_wr_en", k), 32'(pw), 32'(e_pw));
    chk($sformatf("d%0d_fe_id_wr_en", k), 32'(fw), 32'(e_fw));
    chk($sformatf("d%0d_fe_id_flush", k), 32'(fl), 32'(e_fl));
    chk($sformatf("d%0d_fetch_valid", k), 32'(fv), 32'(e_fw & ~e_fl));
    chk($sformatf("d%0d_state", k), 32'(st), 32'(m_mode[k]));
    chk($sformatf("d%0d_stall_cnt", k), 32'(sc), 32'(m_stalls[k]));
    chk($sformatf("d%0d_redirect_cnt", k), 32'(rc), 32'(m_redirs[k]));
  endtask

  task automatic check_all();
    check_one(0, if1.pc_sel, if1.pc_load_addr, if1.pc_wr_en, if1.fe_id_wr_en,
              if1.fe_id_flush, if1.fetch_valid, if1.state_o, if1.stall_cnt, if1.redirect_cnt);
    check_one(1, if2.pc_sel, if2.pc_load_addr, if2.pc_wr_en, if2.fe_id_wr_en,
              if2.fe_id_flush, if2.fetch_valid, if2.state_o,
              {12'd0, if2.stall_cnt}, {12'd0, if2.redirect_cnt});
  endtask

  // one cycle: drive at negedge, check mid-low-phase, then advance the model
  task automatic step(input logic rst, input logic rd, input logic [15:0] ra,
                      input logic st, input logic hl, input logic rs);
    @(negedge clk);
    reset_n = rst; t_redir = rd; t_addr = ra; t_stall = st; t_halt = hl; t_resume = rs;
    if (!rst) model_reset();
    #1;
    check_all();
    model_edge();
  endtask

  initial begin
    reset_n = 1'b0; t_stall = 1'b0; t_redir = 1'b0; t_addr = 16'd0;
    t_halt = 1'b0; t_resume = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    // release: squash slot, then RUN on the 1-slot instance
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("rel_state_run", 32'(if1.state_o), 32'd0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    // three stall cycles in RUN
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("stall_cnt_3", 32'(if1.stall_cnt), 32'd3);
    // redirect to 0x0040
    step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("redirect_cnt_1", 32'(if1.redirect_cnt), 32'd1);
    // redirect with stall, then a second redirect while still flushing
    step(1'b1, 1'b1, 16'h0060, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("stall_cnt_after_redir", 32'(if1.stall_cnt), 32'd3);
    chk("redirect_cnt_3", 32'(if2.redirect_cnt), 32'd3);
    // halt: one valid fetch, stall ignored, resume blocked by halt_req, then RUN
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("resume_run", 32'(if1.state_o), 32'd0);
    // halt again, redirect inside HALT, then asynchronous reset mid-HALT
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_rst_state", 32'(if1.state_o), 32'd1);
    step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    // randomized traffic; the 4-bit counters on the second instance saturate
    for (int i = 0; i < 600; i++) begin
      logic hl;
      hl = t_halt;
      if ($urandom_range(0, 9) == 0) hl = ~hl;
      step(1'b1, ($urandom_range(0, 7) == 0), 16'($urandom) & 16'hfffe,
           ($urandom_range(0, 3) == 0), hl, ($urandom_range(0, 4) == 0));
    end
    chk("stall_cnt_sat", 32'(if2.stall_cnt), 32'd15);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
